// File: rtl/jpeg_dma_seq_pkg.sv
// jpeg_dma_seq_pkg: shared state type, register map and DMA command constants
package jpeg_dma_seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CFG, S_START, S_WAIT, S_HAND, S_NEXT, S_LAST, S_DRAIN} seq_state_t;
  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_PITCH  = 3'd1;
  localparam logic [2:0] REG_EX     = 3'd2;
  localparam logic [2:0] REG_EY     = 3'd3;
  localparam logic [2:0] REG_CTRL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] IDX_CMD    = 3'd4;
  localparam logic [31:0] CMD_START = 32'h1;
  localparam logic [31:0] CMD_NEXT  = 32'h2;
  localparam int DMA_RUN     = 0;
  localparam int DMA_RDY     = 1;
  localparam int CTRL_GO     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_ABORT  = 2;
  localparam int ST_DONE     = 1;
  function automatic logic [31:0] dma_adr(input logic [2:0] idx);
    return {27'b0, idx, 2'b00};
  endfunction
endpackage

// File: rtl/jpeg_dma_seq_regs.sv
// jpeg_dma_seq_regs: CPU register file, frame block total and readback mux
module jpeg_dma_seq_regs
  import jpeg_dma_seq_pkg::*;
#(
  parameter int BLK_CNT_W = 17
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic [2:0]           cfg_adr_i,
  input  logic [31:0]          cfg_dat_i,
  output logic [31:0]          cfg_dat_o,
  input  logic                 busy,
  input  logic                 done,
  input  logic                 err,
  input  logic                 tmo,
  input  logic [BLK_CNT_W-1:0] blocks_done,
  output logic [31:0]          src,
  output logic [11:0]          pitch,
  output logic [7:0]           ex,
  output logic [7:0]           ey,
  output logic                 irq_en,
  output logic                 start,
  output logic                 abort,
  output logic                 clr,
  output logic [BLK_CNT_W-1:0] total
);
  localparam logic [BLK_CNT_W-1:0] ONE = BLK_CNT_W'(1);
  logic wr, ctrl_wr, unused_blk;
  assign wr = cfg_we_i && !busy;
  assign ctrl_wr = cfg_we_i && cfg_adr_i == REG_CTRL;
  assign abort = ctrl_wr && cfg_dat_i[CTRL_ABORT];
  assign start = ctrl_wr && cfg_dat_i[CTRL_GO] && !abort && !busy;
  assign clr = cfg_we_i && cfg_adr_i == REG_STATUS && cfg_dat_i[ST_DONE];
  assign unused_blk = ^blocks_done[BLK_CNT_W-1:16];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      src <= '0;
      pitch <= '0;
      ex <= '0;
      ey <= '0;
      irq_en <= 1'b0;
      total <= '0;
    end else begin
      if (wr && cfg_adr_i == REG_SRC) src <= cfg_dat_i;
      if (wr && cfg_adr_i == REG_PITCH) pitch <= cfg_dat_i[11:0];
      if (wr && cfg_adr_i == REG_EX) ex <= cfg_dat_i[7:0];
      if (wr && cfg_adr_i == REG_EY) ey <= cfg_dat_i[7:0];
      if (ctrl_wr) irq_en <= cfg_dat_i[CTRL_IRQ_EN];
      if (start) total <= (BLK_CNT_W'(ex) + ONE) * (BLK_CNT_W'(ey) + ONE);
    end
  always_comb
    cfg_dat_o = cfg_adr_i == REG_SRC    ? src :
                cfg_adr_i == REG_PITCH  ? {20'b0, pitch} :
                cfg_adr_i == REG_EX     ? {24'b0, ex} :
                cfg_adr_i == REG_EY     ? {24'b0, ey} :
                cfg_adr_i == REG_CTRL   ? {30'b0, irq_en, 1'b0} :
                cfg_adr_i == REG_STATUS ? {blocks_done[15:0], 12'b0, tmo, err, done, busy} : '0;
endmodule

// File: rtl/jpeg_dma_seq.sv
// jpeg_dma_seq: autonomous JPEG DMA sequencer with per-frame interrupt
// Define JPEG_DMA_SEQ_TIMEOUT_EN to enable the WAIT_RDY/DRAIN watchdog.
module jpeg_dma_seq
  import jpeg_dma_seq_pkg::*;
#(
  parameter int BLK_CNT_W = 17,
  parameter int SETTLE    = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_we_i,
  input  logic [2:0]  cfg_adr_i,
  input  logic [31:0] cfg_dat_i,
  output logic [31:0] cfg_dat_o,
  output logic        dmaen_o,
  output logic        dma_we_o,
  output logic [31:0] dma_adr_o,
  output logic [31:0] dma_dat_o,
  input  logic [31:0] dma_status_i,
  output logic        blk_valid_o,
  input  logic        blk_done_i,
  output logic        irq_o
);
`ifdef JPEG_DMA_SEQ_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif
  localparam int CW = $clog2(TIMEOUT + SETTLE + 8);
  localparam logic [BLK_CNT_W-1:0] ONE = BLK_CNT_W'(1);
  seq_state_t state_q, nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BLK_CNT_W-1:0] blk_q, total;
  logic [31:0] src, dat_d;
  logic [11:0] pitch;
  logic [7:0] ex, ey;
  logic [2:0] idx_d;
  logic irq_en, start, abort, clr, done_q, err_q, tmo_q;
  logic busy, settled, tmo_hit, kill, cnt_run, we_d, unused_status;
  jpeg_dma_seq_regs #(.BLK_CNT_W(BLK_CNT_W)) u_regs (
    .clk_i(clk_i), .rst_ni(rst_ni), .cfg_we_i(cfg_we_i), .cfg_adr_i(cfg_adr_i),
    .cfg_dat_i(cfg_dat_i), .cfg_dat_o(cfg_dat_o), .busy(busy), .done(done_q),
    .err(err_q), .tmo(tmo_q), .blocks_done(blk_q), .src(src), .pitch(pitch),
    .ex(ex), .ey(ey), .irq_en(irq_en), .start(start), .abort(abort), .clr(clr),
    .total(total)
  );
  assign unused_status = ^dma_status_i[31:2];
  assign busy = state_q != S_IDLE;
  assign settled = cnt_q >= CW'(SETTLE);
  assign tmo_hit = TMO_EN && (state_q == S_WAIT || state_q == S_DRAIN) && cnt_q == CW'(TIMEOUT - 1);
  assign kill = (busy && abort) || tmo_hit;
  always_comb begin
    nxt = state_q;
    case (state_q)
      S_IDLE:  nxt = start ? S_CFG : S_IDLE;
      S_CFG:   nxt = cnt_q == CW'(3) ? S_START : S_CFG;
      S_START: nxt = S_WAIT;
      S_NEXT:  nxt = S_WAIT;
      S_WAIT:  nxt = settled && dma_status_i[DMA_RDY] ? S_HAND : S_WAIT;
      S_HAND:  nxt = !blk_done_i ? S_HAND : blk_q + ONE == total ? S_LAST : S_NEXT;
      S_LAST:  nxt = S_DRAIN;
      S_DRAIN: nxt = settled && !dma_status_i[DMA_RUN] ? S_IDLE : S_DRAIN;
      default: nxt = S_IDLE;
    endcase
    if (kill) nxt = S_IDLE;
  end
  // One counter serves CFG word index, settle window and watchdog; it restarts on every state change.
  assign cnt_run = state_q == S_CFG || TMO_EN || cnt_q < CW'(SETTLE);
  assign cnt_d = nxt != state_q ? '0 : cnt_run ? cnt_q + CW'(1) : cnt_q;
  assign we_d = nxt inside {S_CFG, S_START, S_NEXT, S_LAST};
  assign idx_d = nxt == S_CFG ? cnt_d[2:0] : IDX_CMD;
  assign dat_d = !we_d ? '0 : nxt == S_START ? CMD_START : nxt != S_CFG ? CMD_NEXT :
                 idx_d == REG_SRC ? src : idx_d == REG_PITCH ? {20'b0, pitch} :
                 idx_d == REG_EX ? {24'b0, ex} : {24'b0, ey};
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      dmaen_o <= 1'b0;
      dma_we_o <= 1'b0;
      dma_adr_o <= '0;
      dma_dat_o <= '0;
      blk_valid_o <= 1'b0;
    end else begin
      state_q <= nxt;
      cnt_q <= cnt_d;
      dmaen_o <= we_d;
      dma_we_o <= we_d;
      dma_adr_o <= we_d ? dma_adr(idx_d) : '0;
      dma_dat_o <= dat_d;
      blk_valid_o <= nxt == S_HAND;
    end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      blk_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      if (clr) begin
        done_q <= 1'b0;
        err_q <= 1'b0;
        tmo_q <= 1'b0;
        irq_o <= 1'b0;
      end
      if (start) begin
        done_q <= 1'b0;
        blk_q <= '0;
      end
      if (state_q == S_HAND && blk_done_i && !kill && blk_q != total) blk_q <= blk_q + ONE;
      if (state_q == S_DRAIN && nxt == S_IDLE && !kill) begin
        done_q <= 1'b1;
        if (irq_en) irq_o <= 1'b1;
      end
      if (kill) begin
        err_q <= 1'b1;
        if (tmo_hit) tmo_q <= 1'b1;
        if (irq_en) irq_o <= 1'b1;
      end
    end
endmodule
